// File: rtl/core_pkg.sv
// Shared execute-stage types: RV32M operation encodings and multiply/divide unit FSM states.
package core_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_t;

    typedef enum logic [2:0] {
        MDU_ST_IDLE     = 3'd0,
        MDU_ST_MUL      = 3'd1,
        MDU_ST_DIV_INIT = 3'd2,
        MDU_ST_DIV_ITER = 3'd3,
        MDU_ST_DIV_FIX  = 3'd4,
        MDU_ST_DONE     = 3'd5
    } mdu_state_t;

    function automatic int unsigned mdu_div_latency(int unsigned xlen, int unsigned div_bits);
        return xlen / div_bits + 2;
    endfunction

    localparam int unsigned MDU_DIV_LATENCY = mdu_div_latency(32, 1);

endpackage

// File: rtl/mdu_divider.sv
// Restoring shift-subtract divider on unsigned magnitudes, DIV_BITS quotient bits per cycle.
module mdu_divider #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DIV_BITS = 1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            last_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    localparam int unsigned ITERS = XLEN / DIV_BITS;
    localparam int unsigned CNT_W = $clog2(ITERS);

    logic [XLEN-1:0]  rem_q, rem_d, quo_q, quo_d, div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic [XLEN-1:0]  rem_step, quo_step;
    logic [XLEN:0]    shifted, trial;

    // quo_q starts as the dividend and is shifted out MSB-first as quotient bits shift in
    always_comb begin
        rem_step = rem_q;
        quo_step = quo_q;
        shifted  = '0;
        trial    = '0;
        for (int i = 0; i < DIV_BITS; i++) begin
            shifted  = {rem_step, quo_step[XLEN-1]};
            trial    = shifted - {1'b0, div_q};
            quo_step = {quo_step[XLEN-2:0], ~trial[XLEN]};
            rem_step = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        end
    end

    always_comb begin
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (abort_i) begin
            active_d = 1'b0;
        end else if (start_i) begin
            rem_d    = '0;
            quo_d    = dividend_i;
            div_d    = divisor_i;
            cnt_d    = CNT_W'(ITERS - 1);
            active_d = 1'b1;
        end else if (active_q) begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign last_o      = active_q && (cnt_q == '0);
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/ex_mdu.sv
// RV32M multi-cycle multiply/divide unit with valid/ready request and tagged result handshakes.
// Define MDU_DIV_EARLY_OUT_EN to finish divides with |a| < |b| in two cycles.
module ex_mdu
    import core_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned DIV_BITS   = 1,
    parameter int unsigned TAG_W      = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  operand_a_i,
    input  logic [XLEN-1:0]  operand_b_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    mdu_state_t       state_q, state_d;
    mdu_op_t          op_q, op_d;
    logic [XLEN-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [2:0]       mul_cnt_q, mul_cnt_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, special_q, special_d;

    logic              signed_div, is_rem, a_neg, b_neg, div_by_zero, overflow, early_out;
    logic              special_case, div_start, div_last;
    logic [XLEN-1:0]   a_mag, b_mag, special_res, fix_res, div_quo, div_rem;
    logic              a_sx, b_sx;
    logic [2*XLEN-1:0] a_ext, b_ext, product;
    logic [XLEN-1:0]   mul_res;

    assign a_sx    = (op_q == MDU_MULH) || (op_q == MDU_MULHSU);
    assign b_sx    = (op_q == MDU_MULH);
    assign a_ext   = {{XLEN{a_sx & a_q[XLEN-1]}}, a_q};
    assign b_ext   = {{XLEN{b_sx & b_q[XLEN-1]}}, b_q};
    assign product = a_ext * b_ext;
    assign mul_res = (op_q == MDU_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

    assign signed_div  = (op_q == MDU_DIV) || (op_q == MDU_REM);
    assign is_rem      = op_q[1];
    assign a_neg       = signed_div & a_q[XLEN-1];
    assign b_neg       = signed_div & b_q[XLEN-1];
    assign a_mag       = a_neg ? -a_q : a_q;
    assign b_mag       = b_neg ? -b_q : b_q;
    assign div_by_zero = (b_q == '0);
    assign overflow    = signed_div && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
`ifdef MDU_DIV_EARLY_OUT_EN
    assign early_out   = !div_by_zero && (a_mag < b_mag);
`else
    assign early_out   = 1'b0;
`endif
    assign special_case = div_by_zero || overflow || early_out;

    always_comb begin
        special_res = is_rem ? a_q : '0;
        if (div_by_zero) begin
            special_res = is_rem ? a_q : '1;
        end else if (overflow) begin
            special_res = is_rem ? '0 : a_q;
        end
    end

    assign fix_res = is_rem ? (r_neg_q ? -div_rem : div_rem)
                            : (q_neg_q ? -div_quo : div_quo);

    mdu_divider #(
        .XLEN     (XLEN),
        .DIV_BITS (DIV_BITS)
    ) u_divider (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .start_i     (div_start),
        .abort_i     (flush_i),
        .dividend_i  (a_mag),
        .divisor_i   (b_mag),
        .last_o      (div_last),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        tag_d     = tag_q;
        result_d  = result_q;
        mul_cnt_d = mul_cnt_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        special_d = special_q;
        div_start = 1'b0;
        unique case (state_q)
            MDU_ST_IDLE: begin
                if (in_valid_i && !flush_i) begin
                    op_d      = mdu_op_t'(op_i);
                    a_d       = operand_a_i;
                    b_d       = operand_b_i;
                    tag_d     = tag_i;
                    mul_cnt_d = 3'(MUL_STAGES - 1);
                    state_d   = op_i[2] ? MDU_ST_DIV_INIT : MDU_ST_MUL;
                end
            end
            MDU_ST_MUL: begin
                if (mul_cnt_q == '0) begin
                    result_d = mul_res;
                    state_d  = MDU_ST_DONE;
                end else begin
                    mul_cnt_d = mul_cnt_q - 1'b1;
                end
            end
            MDU_ST_DIV_INIT: begin
                q_neg_d   = a_neg ^ b_neg;
                r_neg_d   = a_neg;
                special_d = special_case;
                // Special results are settled here; DIV_FIX just holds them for a two-cycle latency
                if (special_case) begin
                    result_d = special_res;
                    state_d  = MDU_ST_DIV_FIX;
                end else begin
                    div_start = !flush_i;
                    state_d   = MDU_ST_DIV_ITER;
                end
            end
            MDU_ST_DIV_ITER: begin
                if (div_last) begin
                    state_d = MDU_ST_DIV_FIX;
                end
            end
            MDU_ST_DIV_FIX: begin
                if (!special_q) begin
                    result_d = fix_res;
                end
                state_d = MDU_ST_DONE;
            end
            MDU_ST_DONE: begin
                if (out_ready_i) begin
                    state_d = MDU_ST_IDLE;
                end
            end
            default: state_d = MDU_ST_IDLE;
        endcase
        if (flush_i) begin
            state_d = MDU_ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= MDU_ST_IDLE;
            op_q      <= MDU_MUL;
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= '0;
            result_q  <= '0;
            mul_cnt_q <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            special_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            tag_q     <= tag_d;
            result_q  <= result_d;
            mul_cnt_q <= mul_cnt_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            special_q <= special_d;
        end
    end

    assign in_ready_o  = (state_q == MDU_ST_IDLE);
    assign busy_o      = (state_q != MDU_ST_IDLE);
    assign out_valid_o = (state_q == MDU_ST_DONE);
    assign result_o    = result_q;
    assign tag_o       = tag_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: expected results go into a scoreboard queue at issue and are
// popped and compared when the unit presents them.
module tb_ex_mdu;
    import core_pkg::*;

    logic        clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [2:0]  op;
    logic [31:0] opa, opb, result;
    logic [4:0]  tag_in, tag_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
    } exp_t;
    exp_t sb[$];

`ifdef MDU_DIV_EARLY_OUT_EN
    localparam bit EarlyOut = 1'b1;
`else
    localparam bit EarlyOut = 1'b0;
`endif

    ex_mdu dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .operand_a_i (opa),
        .operand_b_i (opb),
        .tag_i       (tag_in),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .tag_o       (tag_out),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sbv, ua, ub;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        case (o)
            3'd0: begin p = 64'(sa * sbv); return p[31:0]; end
            3'd1: begin p = 64'(sa * sbv); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub);  return p[63:32]; end
            3'd3: begin p = 64'(ua * ub);  return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sbv);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sbv);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
        bit          sgn;
        logic [31:0] ma, mb;
        if (!o[2]) return 2;
        if (b == 0) return 2;
        sgn = (o == 3'd4) || (o == 3'd6);
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        if (EarlyOut && ma < mb) return 2;
        return 34;
    endfunction

    task automatic drive_req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] t);
        @(negedge clk);
        op = o; opa = a; opb = b; tag_in = t; in_valid = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            check("busy_in_flight", 32'(busy), 32'd1);
        end while (!out_valid && cyc < 100);
        check("out_valid_seen", 32'(out_valid), 32'd1);
    endtask

    // Issue one op, optionally stall the consumer for 'hold' cycles, then retire it.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, input logic [31:0] exp_res, input int hold);
        exp_t e;
        int   cyc;
        e.res = exp_res;
        e.tag = t;
        e.lat = exp_latency(o, a, b);
        sb.push_back(e);
        drive_req(o, a, b, t);
        wait_valid(cyc);
        e = sb.pop_front();
        check("latency", 32'(cyc), 32'(e.lat));
        check("result", result, e.res);
        check("tag", 32'(tag_out), 32'(e.tag));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", result, e.res);
            check("hold_tag", 32'(tag_out), 32'(e.tag));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_after_take", 32'(out_valid), 32'd0);
        check("ready_after_take", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int          cyc;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = '0; opa = '0; opb = '0; tag_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_tag", 32'(tag_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(MDU_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'h0A, 32'hFFFF_FFEB, 0);
        run_op(MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h01, 32'hFFFF_FFFE, 0);
        run_op(MDU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h02, 32'h0000_0000, 0);
        run_op(MDU_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'h03, 32'hFFFF_FFFF, 0);
        run_op(MDU_DIV,    32'hFFFF_FFEC, 32'h0000_0003, 5'h04, 32'hFFFF_FFFA, 0);
        run_op(MDU_REM,    32'hFFFF_FFEC, 32'h0000_0003, 5'h05, 32'hFFFF_FFFE, 0);
        run_op(MDU_DIVU,   32'h0000_1234, 32'h0000_0000, 5'h06, 32'hFFFF_FFFF, 0);
        run_op(MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'h07, 32'h0000_0000, 0);
        run_op(MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'h08, 32'h8000_0000, 0);
        run_op(MDU_REMU,   32'h0000_1234, 32'h0000_0000, 5'h09, 32'h0000_1234, 0);
        run_op(MDU_DIVU,   32'h0000_0005, 32'h0000_0009, 5'h0B, 32'h0000_0000, 0);
        run_op(MDU_REM,    32'hFFFF_FFFB, 32'h0000_0009, 5'h0C, 32'hFFFF_FFFB, 0);

        // Consumer backpressure on a full-length divide
        run_op(MDU_DIV, 32'hFFFF_FFEC, 32'h0000_0003, 5'h1F, 32'hFFFF_FFFA, 5);

        // Flush partway through the iterations, then a multiply right behind it
        drive_req(MDU_DIVU, 32'h1234_5678, 32'h0000_0013, 5'h11);
        repeat (11) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        run_op(MDU_MUL, 32'h0001_0001, 32'h0000_0010, 5'h12, 32'h0010_0010, 0);

        // Flush coincident with a request blocks acceptance
        @(negedge clk);
        op = MDU_MUL; opa = 32'd3; opb = 32'd4; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_blocks_accept", 32'(busy), 32'd0);

        // Flush coincident with out_ready in DONE: no delivery
        drive_req(MDU_MUL, 32'd6, 32'd7, 5'h13);
        wait_valid(cyc);
        @(negedge clk);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; out_ready = 1'b0;
        check("flush_done_valid", 32'(out_valid), 32'd0);
        check("flush_done_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a divide
        drive_req(MDU_DIV, 32'h0000_0100, 32'h0000_0007, 5'h14);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_result", result, 32'd0);
        check("arst_tag", 32'(tag_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mixed operations against the reference model
        for (int i = 0; i < 10; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            run_op(ro, ra, rb, 5'(i + 16), ref_mdu(ro, ra, rb), 0);
        end

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
